// File: rtl/timer_counter_if.sv
// -----------------------------------------------------------------------------
// timer_counter_if
// Control/status bundle between the timer's APB register block and
// timer_counter_core.
//
// Signals:
//   start_counter  reg block -> core  value loaded while load=1
//   load           reg block -> core  level; load start_counter every clk
//   up_down        reg block -> core  0 = up, 1 = down
//   enable         reg block -> core  run prescaler and counter
//   clk_sel        reg block -> core  tick period 2^(clk_sel+1) clks
//   clr_overflow   reg block -> core  one-clk pulse, clears overflow
//   clr_underflow  reg block -> core  one-clk pulse, clears underflow
//   cnt            core -> reg block  registered count
//   overflow       core -> reg block  sticky up-wrap flag
//   underflow      core -> reg block  sticky down-wrap flag
//   irq            core -> reg block  only when TIMER_CNT_IRQ_EN is defined
//
// Handshake: there is no valid/ready pairing on this bundle. Controls are
// levels sampled every clk edge, except the two clear inputs, which are
// single-cycle pulses acted on at the edge where they are high.
//
// Optional macro: TIMER_CNT_IRQ_EN adds the irq signal.
// -----------------------------------------------------------------------------
interface timer_counter_if #(
    parameter int CNT_W = 8
);
    logic [CNT_W-1:0] start_counter;
    logic             load;
    logic             up_down;
    logic             enable;
    logic [1:0]       clk_sel;
    logic             clr_overflow;
    logic             clr_underflow;
    logic [CNT_W-1:0] cnt;
    logic             overflow;
    logic             underflow;
`ifdef TIMER_CNT_IRQ_EN
    logic             irq;

    modport master (
        output start_counter, load, up_down, enable, clk_sel,
               clr_overflow, clr_underflow,
        input  cnt, overflow, underflow, irq
    );

    modport slave (
        input  start_counter, load, up_down, enable, clk_sel,
               clr_overflow, clr_underflow,
        output cnt, overflow, underflow, irq
    );
`else
    modport master (
        output start_counter, load, up_down, enable, clk_sel,
               clr_overflow, clr_underflow,
        input  cnt, overflow, underflow
    );

    modport slave (
        input  start_counter, load, up_down, enable, clk_sel,
               clr_overflow, clr_underflow,
        output cnt, overflow, underflow
    );
`endif
endinterface

// File: rtl/timer_counter_core.sv
// -----------------------------------------------------------------------------
// timer_counter_core
// CNT_W-bit up/down counter advanced by a prescaled tick derived from clk.
// Produces sticky overflow/underflow flags for the status register.
//
// Ports:
//   clk    system clock
//   rst_n  synchronous, active-low reset
//   bus    timer_counter_if.slave (controls in, cnt/flags out)
//
// Optional macro: TIMER_CNT_IRQ_EN adds a registered irq output that is
// the OR of the two flags' next values.
//
// Parameters:
//   CNT_W  counter width (wrap points are all-ones and zero)
//   PSC_W  prescaler width, at least 4 so the /16 tick exists
// -----------------------------------------------------------------------------
module timer_counter_core #(
    parameter int CNT_W = 8,
    parameter int PSC_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    timer_counter_if.slave  bus
);

    logic [PSC_W-1:0] r_psc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_overflow;
    logic             r_underflow;

    logic [PSC_W-1:0] w_mask;
    logic             w_run;
    logic             w_tick;
    logic             w_cnt_ones;
    logic             w_cnt_zero;
    logic             w_ovf_set;
    logic             w_unf_set;
    logic             w_ovf_next;
    logic             w_unf_next;

    // Low clk_sel+1 bits of psc that must all be ones for a tick.
    always_comb begin
        w_mask = '0;
        case (bus.clk_sel)
            2'd0:    w_mask = PSC_W'(4'b0001);
            2'd1:    w_mask = PSC_W'(4'b0011);
            2'd2:    w_mask = PSC_W'(4'b0111);
            default: w_mask = PSC_W'(4'b1111);
        endcase
    end

    // load forces the prescaler idle, so a load also restarts tick phase.
    assign w_run      = bus.enable & ~bus.load;
    assign w_tick     = w_run & ((r_psc & w_mask) == w_mask);
    assign w_cnt_ones = &r_cnt;
    assign w_cnt_zero = ~|r_cnt;

    assign w_ovf_set  = w_tick & ~bus.up_down & w_cnt_ones;
    assign w_unf_set  = w_tick &  bus.up_down & w_cnt_zero;

    // Set beats a same-edge clear so no wrap event is ever lost.
    assign w_ovf_next = w_ovf_set | (r_overflow  & ~bus.clr_overflow);
    assign w_unf_next = w_unf_set | (r_underflow & ~bus.clr_underflow);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_psc       <= '0;
            r_cnt       <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_run) begin
                r_psc <= r_psc + PSC_W'(1);
            end else begin
                r_psc <= '0;
            end

            if (bus.load) begin
                r_cnt <= bus.start_counter;
            end else if (w_tick) begin
                // Natural modular wrap gives 0 / all-ones at the ends.
                if (bus.up_down) begin
                    r_cnt <= r_cnt - CNT_W'(1);
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end

            r_overflow  <= w_ovf_next;
            r_underflow <= w_unf_next;
        end
    end

    assign bus.cnt       = r_cnt;
    assign bus.overflow  = r_overflow;
    assign bus.underflow = r_underflow;

`ifdef TIMER_CNT_IRQ_EN
    logic r_irq;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= w_ovf_next | w_unf_next;
        end
    end

    assign bus.irq = r_irq;
`endif

endmodule

// File: tb/tb_timer_counter_core.sv
// -----------------------------------------------------------------------------
// tb_timer_counter_core
// Directed bench for timer_counter_core. Inputs change 1 time unit after a
// rising edge; outputs are sampled at the same point, so "edge N" below is
// the N-th rising edge after the inputs were applied.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_timer_counter_core;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    timer_counter_if #(.CNT_W(8)) bus ();

    timer_counter_core #(.CNT_W(8), .PSC_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.start_counter = 8'h00;
        bus.load          = 1'b0;
        bus.up_down       = 1'b0;
        bus.enable        = 1'b0;
        bus.clk_sel       = 2'd0;
        bus.clr_overflow  = 1'b0;
        bus.clr_underflow = 1'b0;
    endtask

    task automatic do_load(input logic [7:0] v);
        bus.load          = 1'b1;
        bus.start_counter = v;
        step(1);
        bus.load          = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.start_counter = 8'($urandom_range(0, 255));
            bus.load          = 1'($urandom_range(0, 1));
            bus.up_down       = 1'($urandom_range(0, 1));
            bus.enable        = 1'($urandom_range(0, 1));
            bus.clk_sel       = 2'($urandom_range(0, 3));
            bus.clr_overflow  = 1'($urandom_range(0, 1));
            bus.clr_underflow = 1'($urandom_range(0, 1));
            step(1);
        end
        checks++; if (bus.cnt !== 8'h00) begin errors++; $display("FAIL reset_cnt got=%h exp=00", bus.cnt); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", bus.overflow); end
        checks++; if (bus.underflow !== 1'b0) begin errors++; $display("FAIL reset_unf got=%b exp=0", bus.underflow); end
`ifdef TIMER_CNT_IRQ_EN
        checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", bus.irq); end
`endif
        drive_idle();
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic test_up_wrap_div2();
        do_load(8'hFD);
        checks++; if (bus.cnt !== 8'hFD) begin errors++; $display("FAIL up_load got=%h exp=FD", bus.cnt); end
        bus.enable  = 1'b1;
        bus.up_down = 1'b0;
        bus.clk_sel = 2'd0;
        step(1);
        checks++; if (bus.cnt !== 8'hFD) begin errors++; $display("FAIL up_edge1 got=%h exp=FD", bus.cnt); end
        step(1);
        checks++; if (bus.cnt !== 8'hFE) begin errors++; $display("FAIL up_edge2 got=%h exp=FE", bus.cnt); end
        step(2);
        checks++; if (bus.cnt !== 8'hFF) begin errors++; $display("FAIL up_edge4 got=%h exp=FF", bus.cnt); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL up_ovf_early got=%b exp=0", bus.overflow); end
        step(2);
        checks++; if (bus.cnt !== 8'h00) begin errors++; $display("FAIL up_edge6 got=%h exp=00", bus.cnt); end
        checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL up_ovf_set got=%b exp=1", bus.overflow); end
        checks++; if (bus.underflow !== 1'b0) begin errors++; $display("FAIL up_unf got=%b exp=0", bus.underflow); end
`ifdef TIMER_CNT_IRQ_EN
        checks++; if (bus.irq !== 1'b1) begin errors++; $display("FAIL up_irq got=%b exp=1", bus.irq); end
`endif
    endtask

    task automatic test_clear_collision();
        // edge 7 of the previous run has no tick (psc even)
        bus.clr_overflow = 1'b1;
        step(1);
        bus.clr_overflow = 1'b0;
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL clr_ovf got=%b exp=0", bus.overflow); end
`ifdef TIMER_CNT_IRQ_EN
        checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL clr_irq got=%b exp=0", bus.irq); end
`endif
        do_load(8'hFF);
        step(1);
        bus.clr_overflow = 1'b1;
        step(1);
        bus.clr_overflow = 1'b0;
        checks++; if (bus.cnt !== 8'h00) begin errors++; $display("FAIL coll_cnt got=%h exp=00", bus.cnt); end
        checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL coll_ovf got=%b exp=1", bus.overflow); end
    endtask

    task automatic test_down_wrap_div16();
        do_load(8'h01);
        checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL load_keeps_ovf got=%b exp=1", bus.overflow); end
        bus.enable  = 1'b1;
        bus.up_down = 1'b1;
        bus.clk_sel = 2'd3;
        step(15);
        checks++; if (bus.cnt !== 8'h01) begin errors++; $display("FAIL dn_edge15 got=%h exp=01", bus.cnt); end
        step(1);
        checks++; if (bus.cnt !== 8'h00) begin errors++; $display("FAIL dn_edge16 got=%h exp=00", bus.cnt); end
        checks++; if (bus.underflow !== 1'b0) begin errors++; $display("FAIL dn_unf_early got=%b exp=0", bus.underflow); end
        step(16);
        checks++; if (bus.cnt !== 8'hFF) begin errors++; $display("FAIL dn_edge32 got=%h exp=FF", bus.cnt); end
        checks++; if (bus.underflow !== 1'b1) begin errors++; $display("FAIL dn_unf_set got=%b exp=1", bus.underflow); end
        checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL dn_both_flags got=%b exp=1", bus.overflow); end
        bus.clr_overflow  = 1'b1;
        bus.clr_underflow = 1'b1;
        step(1);
        bus.clr_overflow  = 1'b0;
        bus.clr_underflow = 1'b0;
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL dn_clr_ovf got=%b exp=0", bus.overflow); end
        checks++; if (bus.underflow !== 1'b0) begin errors++; $display("FAIL dn_clr_unf got=%b exp=0", bus.underflow); end
        checks++; if (bus.cnt !== 8'hFF) begin errors++; $display("FAIL dn_hold got=%h exp=FF", bus.cnt); end
    endtask

    task automatic test_pause_resume_div4();
        bus.enable = 1'b0;
        do_load(8'h0F);
        bus.enable  = 1'b1;
        bus.up_down = 1'b0;
        bus.clk_sel = 2'd1;
        step(4);
        checks++; if (bus.cnt !== 8'h10) begin errors++; $display("FAIL pr_reach got=%h exp=10", bus.cnt); end
        bus.enable = 1'b0;
        step(20);
        checks++; if (bus.cnt !== 8'h10) begin errors++; $display("FAIL pr_paused got=%h exp=10", bus.cnt); end
        bus.enable = 1'b1;
        step(3);
        checks++; if (bus.cnt !== 8'h10) begin errors++; $display("FAIL pr_edge3 got=%h exp=10", bus.cnt); end
        step(1);
        checks++; if (bus.cnt !== 8'h11) begin errors++; $display("FAIL pr_edge4 got=%h exp=11", bus.cnt); end
    endtask

    task automatic test_load_priority();
        bus.load          = 1'b1;
        bus.start_counter = 8'h80;
        for (int i = 0; i < 5; i++) begin
            step(1);
            checks++; if (bus.cnt !== 8'h80) begin errors++; $display("FAIL lp_cnt[%0d] got=%h exp=80", i, bus.cnt); end
            checks++; if ({bus.overflow, bus.underflow} !== 2'b00) begin errors++; $display("FAIL lp_flags[%0d] got=%b exp=00", i, {bus.overflow, bus.underflow}); end
        end
        bus.load = 1'b0;
        step(3);
        checks++; if (bus.cnt !== 8'h80) begin errors++; $display("FAIL lp_edge3 got=%h exp=80", bus.cnt); end
        step(1);
        checks++; if (bus.cnt !== 8'h81) begin errors++; $display("FAIL lp_edge4 got=%h exp=81", bus.cnt); end
    endtask

    task automatic test_reset_midrun();
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        checks++; if (bus.cnt !== 8'h00) begin errors++; $display("FAIL midrst_cnt got=%h exp=00", bus.cnt); end
        // prescaler must restart from 0: first /4 tick at edge 4
        step(3);
        checks++; if (bus.cnt !== 8'h00) begin errors++; $display("FAIL midrst_edge3 got=%h exp=00", bus.cnt); end
        step(1);
        checks++; if (bus.cnt !== 8'h01) begin errors++; $display("FAIL midrst_edge4 got=%h exp=01", bus.cnt); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        checks = 0;
        errors = 0;
        drive_idle();
        rst_n = 1'b0;
        test_reset();
        test_up_wrap_div2();
        test_clear_collision();
        test_down_wrap_div16();
        test_pause_resume_div4();
        test_load_priority();
        test_reset_midrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/timer_counter_core.md
Name: timer_counter_core

Overview:
- 8-bit up/down counter with clock prescaler. Sits directly downstream of the timer's APB register block.
- Consumes the register-block controls: start value, load, direction, enable, clock select and flag-clear pulses.
- Produces the count value plus sticky overflow/underflow flags, which are fed back into the status register.
- Single clock domain; count ticks are derived from clk through a prescaler, not a separate clock.

Parameters:
- CNT_W, 8, counter width. start_counter and cnt are CNT_W bits; wrap points are all-ones and zero.
- PSC_W, 4, prescaler width. Must be at least 4 so that the /16 tick is supported.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset; synchronous, active-low
- start_counter  input  CNT_W  value loaded into the counter while load=1
- load  input  1  level; 1 = load start_counter every clk
- up_down  input  1  0 = count up, 1 = count down
- enable  input  1  1 = prescaler and counter run
- clk_sel  input  2  tick period 2^(clk_sel+1) clk cycles: 00=/2, 01=/4, 10=/8, 11=/16
- clr_overflow  input  1  one-clk pulse; clears overflow
- clr_underflow  input  1  one-clk pulse; clears underflow
- cnt  output  CNT_W  current count, registered
- overflow  output  1  sticky flag; set on up-count wrap from all-ones to 0
- underflow  output  1  sticky flag; set on down-count wrap from 0 to all-ones

Behaviour:
- Reset (rst_n=0 at a clk edge): cnt=0, overflow=0, underflow=0, prescaler psc=0. Reset overrides every other input.
- Prescaler:
  - psc is held at 0 when enable=0 or load=1; otherwise it increments by 1 each clk and wraps freely.
  - tick = enable & !load & (psc[clk_sel:0] all ones). tick is combinational from the pre-edge psc value.
  - Consequence: counter updates occur at edges 2^(clk_sel+1), 2·2^(clk_sel+1), ... Edge 1 is the first edge at which enable=1 is sampled.
  - A clk_sel change takes effect immediately through the mask; psc is not cleared.
- Counter priority per clk edge: load, then tick, then hold.
  - load=1: cnt <= start_counter. No flag is set. enable is ignored.
  - tick, up_down=0: cnt <= cnt+1. If cnt was all-ones, cnt <= 0 and overflow is set.
  - tick, up_down=1: cnt <= cnt-1. If cnt was 0, cnt <= all-ones and underflow is set.
  - Otherwise cnt holds.
  - enable falling mid-count: cnt holds its value and psc returns to 0. There is no pending tick.
- Flags:
  - Each flag is set on the same edge that cnt wraps, so it is visible together with the new cnt.
  - clr_overflow / clr_underflow clear the corresponding flag at the next edge.
  - If a set event and the clear pulse occur on the same edge, set wins and the flag stays 1, so no event is lost.
  - Flags are never cleared by load, enable or a direction change.
- Overflow and underflow cannot be set on the same edge. Both flags can be 1 together if direction changes between events.
- No combinational path from any input to cnt, overflow or underflow.

Optional Feature:
- Macro: TIMER_CNT_IRQ_EN.
- Defined: extra output port irq (1 bit), registered. irq <= next overflow | next underflow. It rises on the same edge as the flag and falls on the edge the last set flag clears. Reset value 0.
- Undefined: no irq port; status is polled via the flags only. All other behaviour is identical.

Test Plan:
- Reset: drive random inputs with rst_n=0 for 3 clks -> cnt=00, overflow=0, underflow=0; and irq=0 when enabled.
- Up wrap /2: load=1 start=FD for 1 clk, then load=0, enable=1, up_down=0, clk_sel=00 -> cnt=FE@edge2, FF@edge4, 00@edge6. overflow=1 from edge6; underflow stays 0.
- Clear and collision:
  - clr_overflow pulse -> overflow=0 next edge.
  - Reload FF, then assert clr_overflow on the wrapping tick edge -> cnt=00, overflow=1.
- Down wrap /16: load 01, enable=1, up_down=1, clk_sel=11 -> cnt=00@edge16, FF@edge32. underflow=1 from edge32.
- Pause/resume /4: counting up, drop enable at cnt=10 for 20 clks -> cnt stays 10. Re-enable with clk_sel=01 -> cnt=11 at 4th edge after re-enable.
- Load priority: enable=1 with ticks running, load=1 start=80 for 5 clks -> cnt=80 throughout, no flag change. Counting resumes 2^(clk_sel+1) edges after load falls.
